byte_serial_adder: RTL
======================

Name: byte_serial_adder

Overview:
- Multi-cycle wide adder front-end. Accepts two NBYTES-byte operands plus carry-in over a valid/ready handshake.
- Drives one 8-bit adder slice a byte at a time, LSB first, chaining the carry through a register.
- The slice has sum, carry-out and signed-overflow outputs; the existing adder_8 block is instantiated for it.
- Returns the full-width sum, carry-out and signed overflow over a second valid/ready handshake. Sits between the operand source (register file / ALU decode) and the result consumer.

Parameters:
- NBYTES, 4, operand width in bytes; legal range 1..16.

Ports:
- clk  input  1  clock, all state updates on the rising edge.
- rst  input  1  asynchronous active-high reset.
- in_valid  input  1  operands a, b and ci are valid.
- in_ready  output  1  block can accept operands.
- a  input  8*NBYTES  operand A.
- b  input  8*NBYTES  operand B.
- ci  input  1  carry-in to byte 0.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- s  output  8*NBYTES  sum.
- co  output  1  carry-out of the MSB byte.
- of  output  1  signed (two's-complement) overflow of the full-width add.

Behaviour:
- FSM states: IDLE, RUN, DONE.
- Reset: state=IDLE, byte index=0, carry register=0, operand/working registers=0, s=0, co=0, of=0, out_valid=0.
  - in_ready=0 while rst is high.
  - Reset takes effect asynchronously at any time, including mid-RUN or in DONE. The operation in progress is discarded and no out_valid is produced for it.
- Handshake signals:
  - in_ready = (state==IDLE) && !rst, combinational.
  - out_valid is registered and high only in DONE.
- IDLE, accept edge with in_valid=1:
  - latch a, b, ci into operand registers;
  - load carry register with ci; set index=0;
  - go to RUN.
  - in_valid=0 keeps the FSM in IDLE.
- RUN, one byte per cycle:
  - slice inputs are a_reg[8*idx+:8], b_reg[8*idx+:8] and the carry register;
  - the slice sum is written into working[8*idx+:8];
  - the carry register takes the slice co.
  - idx < NBYTES-1: idx increments.
  - idx == NBYTES-1: s <= working with the final byte merged in, co <= slice co, of <= slice of; go to DONE.
- DONE:
  - out_valid=1; s, co and of are held stable.
  - out_ready=1 at an edge: go to IDLE, out_valid drops on that edge.
  - out_ready=0: hold indefinitely.
- Ignored inputs:
  - in_valid is ignored outside IDLE, with no queuing.
  - out_ready is ignored outside DONE.
- Timing:
  - out_valid rises exactly NBYTES rising edges after the accept edge.
  - Minimum initiation interval is NBYTES+2 cycles: accept, NBYTES RUN cycles, one DONE cycle with out_ready=1.
- Output stability: s, co and of change only on the edge entering DONE (or on reset). The previous result stays visible during RUN.
- Arithmetic:
  - {co,s} = a + b + ci, modulo 2^(8*NBYTES+1).
  - of = carry into bit 8*NBYTES-1 XOR co, taken from the final slice.
- NBYTES=1: single RUN cycle; same rules apply.
- Index width: $clog2(NBYTES) bits, minimum 1. No wrap-around beyond NBYTES-1.

Optional Feature:
- Macro: BYTE_SERIAL_ADDER_SUB_EN.
- Defined:
  - adds input port sub (1 bit), sampled with a at the accept edge;
  - sub=1: each B byte is inverted before the slice, and the carry register is loaded with 1 (ci ignored), giving s = a - b;
  - co=1 means no borrow; of is signed overflow of the subtraction;
  - sub=0: identical to the undefined case.
- Undefined: no sub port; addition only.

Test Plan (NBYTES=4):
- Reset: rst=1 for 3 cycles -> in_ready=0, out_valid=0, s=0x00000000, co=0, of=0; in_ready=1 on the first cycle after release.
- Cross-byte carry: a=0x000000FF, b=0x00000001, ci=0 -> s=0x00000100, co=0, of=0; out_valid rises 4 edges after accept.
- Full carry chain: a=0xFFFFFFFF, b=0x00000000, ci=1 -> s=0x00000000, co=1, of=0. Signed overflow: a=0x7FFFFFFF, b=0x00000001, ci=0 -> s=0x80000000, co=0, of=1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE and pulse in_valid -> s/co/of/out_valid stable, in_ready=0, no accept. Then out_ready=1 -> IDLE next edge, a new op is accepted, and its result is correct.
- Reset mid-op: assert rst during the 2nd RUN cycle -> immediate IDLE, out_valid never rises for that op. Next op a=0x12345678, b=0x11111111 -> s=0x23456789, co=0, of=0.
- With BYTE_SERIAL_ADDER_SUB_EN:
  - sub=1, a=0x00000005, b=0x00000007 -> s=0xFFFFFFFE, co=0, of=0;
  - sub=1, a=0x80000000, b=0x00000001 -> s=0x7FFFFFFF, co=1, of=1.

Source files
------------

// File: rtl/byte_serial_adder.sv
// byte_serial_adder: multi-cycle wide adder that feeds one 8-bit adder slice
// a byte at a time, LSB first, with the carry chained through a register.
// The operand/result handshakes are both valid/ready.
// Optional build macro: BYTE_SERIAL_ADDER_SUB_EN adds a 'sub' input that turns
// the operation into a - b (B bytes inverted, carry seeded with 1).

// 8-bit adder slice with carry-out and two's-complement overflow.
module adder_8 (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       ci,
  output logic [7:0] s,
  output logic       co,
  output logic       of
);

  logic [7:0] low_sum;
  logic [1:0] msb_sum;
  logic       c7;

  // Split at bit 7 so the carry into the sign bit is visible for overflow.
  always_comb begin
    low_sum = 8'({1'b0, a[6:0]}) + 8'({1'b0, b[6:0]}) + 8'(ci);
    c7      = low_sum[7];
    msb_sum = 2'(a[7]) + 2'(b[7]) + 2'(c7);
    s       = {msb_sum[0], low_sum[6:0]};
    co      = msb_sum[1];
    of      = c7 ^ msb_sum[1];
  end

endmodule

module byte_serial_adder #(
  parameter int unsigned NBYTES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [8*NBYTES-1:0]   a,
  input  logic [8*NBYTES-1:0]   b,
  input  logic                  ci,
`ifdef BYTE_SERIAL_ADDER_SUB_EN
  input  logic                  sub,
`endif
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [8*NBYTES-1:0]   s,
  output logic                  co,
  output logic                  of
);

  localparam int unsigned W  = 8 * NBYTES;
  localparam int unsigned IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam int unsigned OW = IW + 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            carry_q, carry_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic [W-1:0]    work_q, work_d;
  logic [W-1:0]    s_q, s_d;
  logic            co_q, co_d;
  logic            of_q, of_d;
  logic            out_valid_q, out_valid_d;

  logic [W-1:0]    b_load;
  logic            carry_load;
  logic [OW-1:0]   byte_off;
  logic [7:0]      slice_a, slice_b, slice_s;
  logic            slice_co, slice_of;
  logic            last_byte;

  // Operand conditioning at accept: optional subtract inverts B and seeds carry.
`ifdef BYTE_SERIAL_ADDER_SUB_EN
  assign b_load     = sub ? ~b : b;
  assign carry_load = sub | ci;
`else
  assign b_load     = b;
  assign carry_load = ci;
`endif

  // Byte selection for the current slice.
  assign byte_off  = {idx_q, 3'b000};
  assign slice_a   = a_q[byte_off +: 8];
  assign slice_b   = b_q[byte_off +: 8];
  assign last_byte = (idx_q == IW'(NBYTES - 1));

  adder_8 u_slice (
    .a  (slice_a),
    .b  (slice_b),
    .ci (carry_q),
    .s  (slice_s),
    .co (slice_co),
    .of (slice_of)
  );

  // Operands are accepted only in IDLE and never while reset is asserted.
  assign in_ready  = (state_q == IDLE) && !rst;
  assign out_valid = out_valid_q;
  assign s         = s_q;
  assign co        = co_q;
  assign of        = of_q;

  // Next-state and datapath update.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    carry_d     = carry_q;
    a_d         = a_q;
    b_d         = b_q;
    work_d      = work_q;
    s_d         = s_q;
    co_d        = co_q;
    of_d        = of_q;
    out_valid_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b_load;
          carry_d = carry_load;
          idx_d   = '0;
          state_d = RUN;
        end
      end

      RUN: begin
        work_d[byte_off +: 8] = slice_s;
        carry_d               = slice_co;
        if (last_byte) begin
          s_d         = work_d;
          co_d        = slice_co;
          of_d        = slice_of;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end

      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end else begin
          out_valid_d = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset discards any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      carry_q     <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      work_q      <= '0;
      s_q         <= '0;
      co_q        <= 1'b0;
      of_q        <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      carry_q     <= carry_d;
      a_q         <= a_d;
      b_q         <= b_d;
      work_q      <= work_d;
      s_q         <= s_d;
      co_q        <= co_d;
      of_q        <= of_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule
